// File: rtl/sr_ex_wb_stage_if.sv
// rtl/sr_ex_wb_stage_if.sv - execute-side and writeback-side signal bundle of sr_ex_wb_stage
//
// Purpose: groups the execute handshake/payload, the writeback handshake/payload
// and the branch redirect outputs of the EX->WB stage into one interface.
//
// Signals:
//   ex_valid, ex_ready         execute-side handshake
//   alu_result, alu_zero       ALU outputs for the instruction in EX
//   ex_rd, ex_we, ex_br        destination, write enable, branch type
//   ex_pc, ex_imm              instruction PC and sign-extended branch offset
//   wb_valid, wb_ready         writeback-side handshake
//   wb_rd, wb_data, wb_we      head entry of the skid FIFO
//   redirect_valid, redirect_pc taken-branch pulse and target
//
// Modports:
//   slave  - the stage itself (consumes ex_*, produces wb_* and redirect_*)
//   master - the surrounding pipeline (produces ex_*, consumes wb_* and redirect_*)

interface sr_ex_wb_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic [1:0]  ex_br;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_we;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport slave (
    input  ex_valid, alu_result, alu_zero, ex_rd, ex_we, ex_br, ex_pc, ex_imm,
    input  wb_ready,
    output ex_ready,
    output wb_valid, wb_rd, wb_data, wb_we,
    output redirect_valid, redirect_pc
  );

  modport master (
    output ex_valid, alu_result, alu_zero, ex_rd, ex_we, ex_br, ex_pc, ex_imm,
    output wb_ready,
    input  ex_ready,
    input  wb_valid, wb_rd, wb_data, wb_we,
    input  redirect_valid, redirect_pc
  );
endinterface

// File: rtl/sr_ex_wb_stage.sv
// rtl/sr_ex_wb_stage.sv - schoolRISCV execute-to-writeback stage with 2-entry skid FIFO
//
// Purpose: captures ALU result, destination and write enable of each accepted
// instruction into a 2-entry circular FIFO feeding register-file writeback, and
// resolves BEQ/BNE from the ALU zero flag into a one-cycle redirect pulse.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   bus            sr_ex_wb_stage_if.slave (ex_*, wb_*, redirect_*)
//   retire_cnt     (SR_EX_WB_PERF_EN only) pops since reset, wraps
//   taken_cnt      (SR_EX_WB_PERF_EN only) redirect pulses since reset, wraps
//
// Configuration macro: SR_EX_WB_PERF_EN adds the two performance counters.

module sr_ex_wb_stage #(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  sr_ex_wb_stage_if.slave   bus
`ifdef SR_EX_WB_PERF_EN
  ,
  output logic [31:0]       retire_cnt,
  output logic [31:0]       taken_cnt
`endif
);

  localparam logic [1:0] FULL_CNT = DEPTH[1:0];

  logic [31:0] data_q [2];
  logic [4:0]  rd_q   [2];
  logic        we_q   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic push;
  logic pop;
  logic taken;

  // ex_ready depends only on the registered count, so wb_ready never reaches it
  assign bus.ex_ready = (count != FULL_CNT);
  assign bus.wb_valid = (count != 2'd0);

  // Head is read straight out of storage: no bubble between push and visibility
  assign bus.wb_data = data_q[rd_ptr];
  assign bus.wb_rd   = rd_q[rd_ptr];
  assign bus.wb_we   = we_q[rd_ptr];

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;

  assign push  = bus.ex_valid && bus.ex_ready;
  assign pop   = bus.wb_valid && bus.wb_ready;
  // Branch type 3 is reserved and behaves like a non-branch
  assign taken = push && (((bus.ex_br == 2'd1) &&  bus.alu_zero) ||
                          ((bus.ex_br == 2'd2) && !bus.alu_zero));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q[0]        <= '0;
      data_q[1]        <= '0;
      rd_q[0]          <= '0;
      rd_q[1]          <= '0;
      we_q[0]          <= 1'b0;
      we_q[1]          <= 1'b0;
      rd_ptr           <= 1'b0;
      wr_ptr           <= 1'b0;
      count            <= 2'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr] <= bus.alu_result;
        rd_q[wr_ptr]   <= bus.ex_rd;
        // x0 is hardwired to zero, so its write enable is dropped at capture
        we_q[wr_ptr]   <= bus.ex_we && (bus.ex_rd != 5'd0);
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      redirect_valid_q <= taken;
      if (taken) begin
        redirect_pc_q <= bus.ex_pc + bus.ex_imm;
      end
    end
  end

`ifdef SR_EX_WB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      taken_cnt  <= '0;
    end else begin
      if (pop) begin
        retire_cnt <= retire_cnt + 32'd1;
      end
      if (redirect_valid_q) begin
        taken_cnt <= taken_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sr_ex_wb_stage.sv
// tb/tb_sr_ex_wb_stage.sv - self-checking bench for sr_ex_wb_stage

module tb_sr_ex_wb_stage;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sr_ex_wb_stage_if bus();

`ifdef SR_EX_WB_PERF_EN
  logic [31:0] retire_cnt;
  logic [31:0] taken_cnt;
`endif

  sr_ex_wb_stage #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SR_EX_WB_PERF_EN
    ,
    .retire_cnt (retire_cnt),
    .taken_cnt  (taken_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a bounded queue of completed instructions plus redirect state
  ent_t        exp_q[$];
  logic        exp_redir = 1'b0;
  logic [31:0] exp_redir_pc = 32'h0;

  task automatic idle_inputs();
    bus.ex_valid   = 1'b0;
    bus.alu_result = 32'h0;
    bus.alu_zero   = 1'b0;
    bus.ex_rd      = 5'd0;
    bus.ex_we      = 1'b0;
    bus.ex_br      = 2'd0;
    bus.ex_pc      = 32'h0;
    bus.ex_imm     = 32'h0;
  endtask

  task automatic offer(input logic [31:0] res, input logic [4:0] rd, input logic we,
                       input logic [1:0] br, input logic zero,
                       input logic [31:0] pc, input logic [31:0] imm);
    bus.ex_valid   = 1'b1;
    bus.alu_result = res;
    bus.ex_rd      = rd;
    bus.ex_we      = we;
    bus.ex_br      = br;
    bus.alu_zero   = zero;
    bus.ex_pc      = pc;
    bus.ex_imm     = imm;
  endtask

  // Advance one clock and update the model from the inputs as driven
  task automatic tick();
    logic        push;
    logic        pop;
    logic        tk;
    ent_t        e;
    ent_t        dropped;
    logic [31:0] tgt;
    push   = bus.ex_valid && (exp_q.size() < 2);
    pop    = bus.wb_ready && (exp_q.size() > 0);
    tk     = push && ((bus.ex_br == 2'd1 && bus.alu_zero) || (bus.ex_br == 2'd2 && !bus.alu_zero));
    e.we   = bus.ex_we && (bus.ex_rd != 5'd0);
    e.rd   = bus.ex_rd;
    e.data = bus.alu_result;
    tgt    = bus.ex_pc + bus.ex_imm;
    @(posedge clk);
    if (pop) dropped = exp_q.pop_front();
    if (push) exp_q.push_back(e);
    exp_redir = tk;
    if (tk) exp_redir_pc = tgt;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.wb_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b expected 0", bus.wb_valid); end
    checks++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d expected 0", bus.wb_rd); end
    checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data: got %h expected 0", bus.wb_data); end
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL reset_wb_we: got %b expected 0", bus.wb_we); end
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect_valid: got %b expected 0", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h expected 0", bus.redirect_pc); end
    checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL reset_ex_ready: got %b expected 1", bus.ex_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    bus.wb_ready = 1'b1;
    offer(32'h0000_00A5, 5'd3, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    idle_inputs();
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL single_wb_valid: got %b expected 1", bus.wb_valid); end
    checks++; if (bus.wb_rd !== 5'd3) begin errors++; $display("FAIL single_wb_rd: got %0d expected 3", bus.wb_rd); end
    checks++; if (bus.wb_data !== 32'hA5) begin errors++; $display("FAIL single_wb_data: got %h expected a5", bus.wb_data); end
    checks++; if (bus.wb_we !== 1'b1) begin errors++; $display("FAIL single_wb_we: got %b expected 1", bus.wb_we); end
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL single_redirect: got %b expected 0", bus.redirect_valid); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL single_drained: got %b expected 0", bus.wb_valid); end
  endtask

  task automatic test_backpressure();
    bus.wb_ready = 1'b0;
    offer(32'h11, 5'd1, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    offer(32'h22, 5'd2, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    offer(32'h33, 5'd3, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
    checks++; if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got ex_ready %b expected 0", bus.ex_ready); end
    checks++; if (bus.wb_data !== 32'h11) begin errors++; $display("FAIL bp_head0: got %h expected 11", bus.wb_data); end
    tick();
    checks++; if (bus.ex_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full: got ex_ready %b expected 0", bus.ex_ready); end
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h11 || bus.wb_rd !== 5'd1) begin errors++; $display("FAIL bp_stable: got v=%b d=%h rd=%0d expected v=1 d=11 rd=1", bus.wb_valid, bus.wb_data, bus.wb_rd); end
    bus.wb_ready = 1'b1;
    tick();
    checks++; if (bus.wb_data !== 32'h22) begin errors++; $display("FAIL bp_head1: got %h expected 22", bus.wb_data); end
    checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL bp_space: got ex_ready %b expected 1", bus.ex_ready); end
    tick();
    idle_inputs();
    checks++; if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'h33) begin errors++; $display("FAIL bp_head2: got v=%b d=%h expected v=1 d=33", bus.wb_valid, bus.wb_data); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", bus.wb_valid); end
  endtask

  task automatic test_x0_suppress();
    bus.wb_ready = 1'b1;
    offer(32'hDEAD_BEEF, 5'd0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    idle_inputs();
    checks++; if (bus.wb_we !== 1'b0) begin errors++; $display("FAIL x0_we: got %b expected 0", bus.wb_we); end
    checks++; if (bus.wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL x0_data: got %h expected deadbeef", bus.wb_data); end
    tick();
  endtask

  task automatic test_branch();
    bus.wb_ready = 1'b1;
    offer(32'h0, 5'd0, 1'b0, 2'd1, 1'b1, 32'h100, 32'hFFFF_FFF0);
    tick();
    offer(32'h0, 5'd0, 1'b0, 2'd2, 1'b1, 32'h300, 32'h40);
    checks++; if (bus.redirect_valid !== 1'b1) begin errors++; $display("FAIL beq_pulse: got %b expected 1", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h0F0) begin errors++; $display("FAIL beq_target: got %h expected f0", bus.redirect_pc); end
    tick();
    offer(32'h0, 5'd0, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h8);
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL bne_not_taken: got %b expected 0", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h0F0) begin errors++; $display("FAIL redirect_pc_hold: got %h expected f0", bus.redirect_pc); end
    tick();
    offer(32'h0, 5'd0, 1'b0, 2'd3, 1'b1, 32'h2000, 32'h8);
    checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h1008) begin errors++; $display("FAIL bne_taken: got v=%b pc=%h expected v=1 pc=1008", bus.redirect_valid, bus.redirect_pc); end
    tick();
    idle_inputs();
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL reserved_br: got %b expected 0", bus.redirect_valid); end
    tick();
    tick();
  endtask

  task automatic test_wrap_simultaneous();
    logic [31:0] sent[10];
    logic [31:0] got[$];
    int idx;
    int cyc;
    foreach (sent[i]) sent[i] = $urandom;
    idx = 0;
    cyc = 0;
    while (got.size() < 10 && cyc < 100) begin
      if (idx < 10) offer(sent[idx], 5'd7, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
      else idle_inputs();
      bus.wb_ready = cyc[0];
      checks++; if (bus.ex_ready !== (exp_q.size() < 2)) begin errors++; $display("FAIL wrap_ex_ready cyc %0d: got %b expected %b", cyc, bus.ex_ready, exp_q.size() < 2); end
      if (bus.wb_valid && bus.wb_ready) got.push_back(bus.wb_data);
      if (bus.ex_valid && bus.ex_ready) idx++;
      tick();
      cyc++;
    end
    idle_inputs();
    checks++; if (got.size() != 10) begin errors++; $display("FAIL wrap_count: got %0d entries expected 10", got.size()); end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      checks++; if (got[i] !== sent[i]) begin errors++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, got[i], sent[i]); end
    end
    bus.wb_ready = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      bus.ex_valid   = ($urandom_range(0, 3) != 0);
      bus.alu_result = $urandom;
      bus.alu_zero   = $urandom_range(0, 1);
      bus.ex_rd      = $urandom_range(0, 31);
      bus.ex_we      = $urandom_range(0, 1);
      bus.ex_br      = $urandom_range(0, 3);
      bus.ex_pc      = $urandom;
      bus.ex_imm     = $urandom;
      bus.wb_ready   = ($urandom_range(0, 2) != 0);
      checks++; if (bus.wb_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_wb_valid c%0d: got %b expected %b", c, bus.wb_valid, exp_q.size() != 0); end
      checks++; if (bus.ex_ready !== (exp_q.size() < 2)) begin errors++; $display("FAIL rnd_ex_ready c%0d: got %b expected %b", c, bus.ex_ready, exp_q.size() < 2); end
      if (exp_q.size() != 0) begin
        checks++; if ({bus.wb_we, bus.wb_rd, bus.wb_data} !== exp_q[0]) begin errors++; $display("FAIL rnd_head c%0d: got %h expected %h", c, {bus.wb_we, bus.wb_rd, bus.wb_data}, exp_q[0]); end
      end
      checks++; if (bus.redirect_valid !== exp_redir) begin errors++; $display("FAIL rnd_redirect c%0d: got %b expected %b", c, bus.redirect_valid, exp_redir); end
      checks++; if (bus.redirect_pc !== exp_redir_pc) begin errors++; $display("FAIL rnd_redirect_pc c%0d: got %h expected %h", c, bus.redirect_pc, exp_redir_pc); end
      tick();
    end
    idle_inputs();
    bus.wb_ready = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_midop();
    bus.wb_ready = 1'b0;
    offer(32'h44, 5'd5, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0);
    tick();
    offer(32'h55, 5'd6, 1'b1, 2'd1, 1'b1, 32'h200, 32'h20);
    tick();
    idle_inputs();
    checks++; if (bus.redirect_valid !== 1'b1 || bus.ex_ready !== 1'b0) begin errors++; $display("FAIL midop_setup: got redir=%b ex_ready=%b expected 1 0", bus.redirect_valid, bus.ex_ready); end
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_redir = 1'b0;
    exp_redir_pc = 32'h0;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL midop_wb_valid: got %b expected 0", bus.wb_valid); end
    checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL midop_redirect: got %b expected 0", bus.redirect_valid); end
    checks++; if (bus.redirect_pc !== 32'h0) begin errors++; $display("FAIL midop_redirect_pc: got %h expected 0", bus.redirect_pc); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick();
    checks++; if (bus.ex_ready !== 1'b1) begin errors++; $display("FAIL midop_ex_ready: got %b expected 1", bus.ex_ready); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL midop_empty: got %b expected 0", bus.wb_valid); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_backpressure();
    test_x0_suppress();
    test_branch();
    test_wrap_simultaneous();
    test_random();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
